// File: rtl/tx_crc_append_pkg.sv
// -----------------------------------------------------------------------------
// tx_crc_append_pkg
// Shared definitions for the transmit FCS path: CRC-32 constants, the FSM
// state encodings of tx_crc_append and a helper that decodes the 3-bit byte
// count used on the 64-bit lane stream (0 encodes a full 8-byte beat).
// -----------------------------------------------------------------------------
package tx_crc_append_pkg;

  // IEEE 802.3 CRC-32 generator polynomial, normal (MSB-first) form.
  localparam logic [31:0] CRC32_POLY       = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT_ALLONES = 32'hFFFF_FFFF;
  // Remainder a receiver sees after folding data plus a correct FCS,
  // expressed in MSB-first form.
  localparam logic [31:0] CRC_RESIDUE      = 32'hC704_DD7B;

  // FSM encodings, kept as plain constants for legacy tool compatibility.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_EXTRA = 2'd2;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Ethernet shifts each byte LSB-first, so the engine runs on the
  // bit-reflected polynomial (0xEDB88320).
  localparam logic [31:0] CRC32_POLY_REFL = reflect32(CRC32_POLY);

  // Byte count on the bus: 1..7 as is, 0 means 8.
  function automatic logic [3:0] byte_count(input logic [2:0] b);
    return (b == 3'd0) ? 4'd8 : {1'b0, b};
  endfunction

endpackage

// File: rtl/crc32_d64_be.sv
// -----------------------------------------------------------------------------
// crc32_d64_be
// Combinational next-state function of the reflected Ethernet CRC-32 over one
// 64-bit beat. Lanes 0..n-1 are folded in lane order (lane 0 first on the
// wire), each byte LSB-first; higher lanes are ignored.
//   crc_i   [31:0]  current CRC register
//   data_i  [63:0]  beat, lane k = bits [8k+7:8k]
//   bytes_i [2:0]   number of lanes to fold, 0 means 8
//   crc_o   [31:0]  CRC register after folding
// -----------------------------------------------------------------------------
module crc32_d64_be
  import tx_crc_append_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [63:0] data_i,
  input  logic [2:0]  bytes_i,
  output logic [31:0] crc_o
);

  logic [3:0] n_lanes;

  // NOTE: combinational blocks use blocking '=' so each loop step sees the
  // previous step's value; every output gets a default at the top so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    n_lanes = byte_count(bytes_i);
    crc_o   = crc_i;
    for (int lane = 0; lane < 8; lane++) begin
      if (4'(lane) < n_lanes) begin
        crc_o = crc_o ^ {24'h0, data_i[8*lane +: 8]};
        for (int b = 0; b < 8; b++) begin
          crc_o = crc_o[0] ? ((crc_o >> 1) ^ CRC32_POLY_REFL) : (crc_o >> 1);
        end
      end
    end
  end

endmodule

// File: rtl/tx_crc_append.sv
// -----------------------------------------------------------------------------
// tx_crc_append
// Transmit-side FCS generator between the frame assembler and the XGMII
// encoder. Computes the Ethernet CRC-32 over each frame on a 64-bit lane
// stream and appends the 4-byte FCS after the last payload byte, inserting
// one extra output beat (and stalling upstream for it) when the FCS does not
// fit in the final input beat. Output is registered: one cycle of latency.
//   txclk, reset       clock, asynchronous active-low reset
//   in_data/valid/sop/eop/bytes, in_ready    upstream beat interface
//   out_data/valid/sop/eop/bytes             downstream (always accepts)
// -----------------------------------------------------------------------------
module tx_crc_append
  import tx_crc_append_pkg::*;
#(
  parameter int          TP       = 1,
  parameter logic [31:0] CRC_INIT = CRC_INIT_ALLONES
) (
  input  logic        txclk,
  input  logic        reset,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [2:0]  in_bytes,
  output logic        in_ready,
  output logic [63:0] out_data,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic [2:0]  out_bytes
);

  // TP only delayed assignments in the behavioural model this replaces; the
  // registers here update with zero delay. It stays so existing
  // instantiations keep binding.
  if (TP < 0) begin : g_tp_legacy
  end

  logic [1:0]  state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] fcs_rem_q, fcs_rem_d;     // FCS bytes left for the EXTRA beat
  logic [2:0]  rem_bytes_q, rem_bytes_d;
  logic [63:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_sop_q, out_sop_d;
  logic        out_eop_q, out_eop_d;
  logic [2:0]  out_bytes_q, out_bytes_d;

  logic        accept, take_beat;
  logic [2:0]  fold_bytes;
  logic [31:0] crc_seed, crc_next, fcs;
  logic [3:0]  n_eop;
  logic [63:0] lane_mask, fcs_lanes, eop_data;

  assign in_ready = (state_q != ST_EXTRA);
  assign accept   = in_valid & in_ready;
  // Outside a frame only a sop beat is taken; anything else is dropped.
  assign take_beat = accept & (in_sop | (state_q == ST_DATA));

  // A sop beat restarts the CRC from the preset before its own bytes fold in,
  // which also abandons any frame still open.
  assign crc_seed   = in_sop ? CRC_INIT : crc_q;
  assign fold_bytes = in_eop ? in_bytes : 3'd0;

  crc32_d64_be u_crc (
    .crc_i   (crc_seed),
    .data_i  (in_data),
    .bytes_i (fold_bytes),
    .crc_o   (crc_next)
  );

  assign fcs   = ~crc_next;
  assign n_eop = byte_count(in_bytes);

  always_comb begin
    lane_mask = '0;
    for (int lane = 0; lane < 8; lane++) begin
      lane_mask[8*lane +: 8] = (4'(lane) < n_eop) ? 8'hFF : 8'h00;
    end
  end

  // FCS placed right after the last data byte; bytes that run past lane 7
  // fall off here and are sent in the EXTRA beat.
  assign fcs_lanes = 64'(fcs) << {n_eop, 3'b000};
  assign eop_data  = (in_data & lane_mask) | fcs_lanes;

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    fcs_rem_d   = fcs_rem_q;
    rem_bytes_d = rem_bytes_q;
    out_data_d  = '0;
    out_valid_d = 1'b0;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    out_bytes_d = 3'd0;

    if (state_q == ST_EXTRA) begin
      out_valid_d = 1'b1;
      out_eop_d   = 1'b1;
      out_data_d  = {32'h0, fcs_rem_q};
      out_bytes_d = rem_bytes_q;
      state_d     = ST_IDLE;
    end else if (take_beat) begin
      out_valid_d = 1'b1;
      out_sop_d   = in_sop;
      crc_d       = crc_next;
      state_d     = ST_DATA;
      if (!in_eop) begin
        out_data_d = in_data;
      end else if (n_eop <= 4'd4) begin
        out_data_d  = eop_data;
        out_eop_d   = 1'b1;
        out_bytes_d = in_bytes + 3'd4;   // (n+4) mod 8, with 0 meaning 8
        state_d     = ST_IDLE;
      end else begin
        out_data_d  = eop_data;
        // Remaining n-4 FCS bytes shifted down to lane 0, upper lanes zero.
        fcs_rem_d   = fcs >> {(4'd8 - n_eop), 3'b000};
        rem_bytes_d = in_bytes - 3'd4;   // n-4; n=8 (code 0) gives 4
        state_d     = ST_EXTRA;
      end
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge txclk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      crc_q       <= CRC_INIT;
      fcs_rem_q   <= '0;
      rem_bytes_q <= 3'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_bytes_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      fcs_rem_q   <= fcs_rem_d;
      rem_bytes_q <= rem_bytes_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_bytes_q <= out_bytes_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_bytes = out_bytes_q;

endmodule

// File: tb/tb_tx_crc_append.sv
// -----------------------------------------------------------------------------
// tb_tx_crc_append
// Directed bench for tx_crc_append: reset values, dropped non-sop beats, the
// "123456789" check string, the extra FCS beat, a sweep of eop byte counts,
// back-to-back frames across an EXTRA stall, sop in mid-frame and reset in
// the middle of a frame.
// -----------------------------------------------------------------------------
module tb_tx_crc_append;
  import tx_crc_append_pkg::*;

  logic        txclk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic [2:0]  in_bytes = 3'd0;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic [2:0]  out_bytes;

  always #5 txclk = ~txclk;

  tx_crc_append dut (
    .txclk     (txclk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_bytes  (in_bytes),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_bytes (out_bytes)
  );

  int total = 0;
  int bad   = 0;

  byte unsigned rx_bytes[$];
  byte unsigned exp_bytes[$];
  logic [31:0]  res_q[$];
  int           rx_beats, rx_sops, rx_eops, first_wait;
  logic [2:0]   last_out_bytes;
  logic [31:0]  model_crc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input byte unsigned b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Index of first difference between received and expected streams, -1 if equal.
  function automatic int first_diff();
    if (rx_bytes.size() != exp_bytes.size()) return -2;
    foreach (rx_bytes[i]) if (rx_bytes[i] !== exp_bytes[i]) return i;
    return -1;
  endfunction

  function automatic logic [63:0] pack_beat(input byte unsigned f[$], input int beat);
    logic [63:0] d;
    d = '0;
    for (int l = 0; l < 8; l++) if (8*beat + l < f.size()) d[8*l +: 8] = f[8*beat + l];
    return d;
  endfunction

  task automatic clear_rx();
    rx_bytes.delete(); exp_bytes.delete(); res_q.delete();
    rx_beats = 0; rx_sops = 0; rx_eops = 0; first_wait = 0;
    last_out_bytes = 3'd0; model_crc = 32'hFFFF_FFFF;
  endtask

  // One clock; sample #1 after the edge and log any output beat.
  task automatic tick();
    int nb;
    logic [63:0] hi;
    @(posedge txclk); #1;
    if (out_valid === 1'b1) begin
      nb = out_eop ? ((out_bytes == 3'd0) ? 8 : int'(out_bytes)) : 8;
      if (out_sop) begin model_crc = 32'hFFFF_FFFF; rx_sops++; end
      for (int i = 0; i < nb; i++) begin
        rx_bytes.push_back(out_data[8*i +: 8]);
        model_crc = crc_byte(model_crc, out_data[8*i +: 8]);
      end
      rx_beats++;
      if (out_eop) begin
        hi = out_data;
        for (int i = 0; i < nb; i++) hi[8*i +: 8] = 8'h00;
        total++;
        if (hi !== 64'h0) begin bad++; $display("FAIL unused_lanes_zero got=%h want=0", hi); end
        rx_eops++;
        last_out_bytes = out_bytes;
        res_q.push_back(bitrev32(model_crc));
      end
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic s, input logic e,
                           input logic [2:0] nb, output int waited);
    in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e; in_bytes = nb;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 8) begin tick(); waited++; end
    if (waited >= 8) begin
      total++; bad++;
      $display("FAIL ready_timeout got in_ready=%b want 1", in_ready);
    end
    tick();
  endtask

  task automatic send_frame(input byte unsigned f[$]);
    int nbeats, nlast, w;
    logic [31:0] c;
    nbeats = (f.size() + 7) / 8;
    c = 32'hFFFF_FFFF;
    foreach (f[i]) c = crc_byte(c, f[i]);
    c = ~c;
    for (int b = 0; b < nbeats; b++) begin
      nlast = f.size() - 8*b;
      send_beat(pack_beat(f, b), b == 0, b == nbeats - 1,
                (b == nbeats - 1) ? 3'(nlast % 8) : 3'd0, w);
      if (b == 0) first_wait = w;
    end
    foreach (f[i]) exp_bytes.push_back(f[i]);
    for (int k = 0; k < 4; k++) exp_bytes.push_back(c[8*k +: 8]);
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    repeat (cycles) tick();
  endtask

  task automatic check_outputs_zero(input string name);
    total++;
    if ({out_valid, out_sop, out_eop, out_bytes, out_data} !== 70'h0) begin
      bad++;
      $display("FAIL %s_out_zero got v=%b s=%b e=%b b=%0d d=%h want all 0",
               name, out_valid, out_sop, out_eop, out_bytes, out_data);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready got=%b want=1", name, in_ready); end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge txclk);
    #1;
    check_outputs_zero("reset");
    @(negedge txclk);
    reset = 1'b1;
    clear_rx();
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_idle_drop();
    clear_rx();
    in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = 64'hDEAD_BEEF_0123_4567;
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_drop_valid got=%b want=0", out_valid); end
    idle(1);
  endtask

  task automatic test_check_string();
    int w;
    clear_rx();
    send_beat(64'h3837_3635_3433_3231, 1'b1, 1'b0, 3'd0, w);
    total++;
    if ({out_valid, out_sop, out_eop} !== 3'b110 || out_data !== 64'h3837_3635_3433_3231) begin
      bad++;
      $display("FAIL chk_beat0 got v/s/e=%b%b%b d=%h want 110 d=3837363534333231",
               out_valid, out_sop, out_eop, out_data);
    end
    send_beat(64'h39, 1'b0, 1'b1, 3'd1, w);
    total++;
    if (out_data !== 64'h0000_00CB_F439_2639) begin
      bad++; $display("FAIL chk_fcs_data got=%h want=000000cbf4392639", out_data);
    end
    total++;
    if ({out_valid, out_sop, out_eop, out_bytes} !== {3'b101, 3'd5}) begin
      bad++; $display("FAIL chk_eop_flags got v/s/e=%b%b%b bytes=%0d want 101 bytes=5",
                      out_valid, out_sop, out_eop, out_bytes);
    end
    idle(1);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL chk_gap_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_extra_beat();
    int w;
    clear_rx();
    send_beat(64'h3837_3635_3433_3231, 1'b1, 1'b1, 3'd0, w);
    total++;
    if ({out_valid, out_sop, out_eop} !== 3'b110 || out_data !== 64'h3837_3635_3433_3231) begin
      bad++; $display("FAIL extra_beat0 got v/s/e=%b%b%b d=%h want 110 d=3837363534333231",
                      out_valid, out_sop, out_eop, out_data);
    end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL extra_ready_low got=%b want=0", in_ready); end
    idle(1);
    total++;
    if (out_data !== 64'h0000_0000_9AE0_DAAF || out_eop !== 1'b1 || out_bytes !== 3'd4
        || out_sop !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL extra_fcs got d=%h e=%b b=%0d s=%b v=%b want d=000000009ae0daaf e=1 b=4 s=0 v=1",
                      out_data, out_eop, out_bytes, out_sop, out_valid);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL extra_ready_back got=%b want=1", in_ready); end
    idle(1);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL extra_after_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_bytes_sweep();
    int want_ob[8] = '{5, 6, 7, 0, 1, 2, 3, 4};
    byte unsigned f[$];
    for (int n = 1; n <= 8; n++) begin
      clear_rx();
      f.delete();
      for (int i = 0; i < 56 + n; i++) f.push_back(8'((i * 13 + n * 29) & 8'hFF));
      send_frame(f);
      idle(3);
      total++;
      if (last_out_bytes !== 3'(want_ob[n-1])) begin
        bad++; $display("FAIL sweep_n%0d_out_bytes got=%0d want=%0d", n, last_out_bytes, want_ob[n-1]);
      end
      total++;
      if (rx_beats != ((n >= 5) ? 9 : 8)) begin
        bad++; $display("FAIL sweep_n%0d_beats got=%0d want=%0d", n, rx_beats, (n >= 5) ? 9 : 8);
      end
      total++;
      if (res_q.size() != 1 || res_q[0] !== CRC_RESIDUE) begin
        bad++; $display("FAIL sweep_n%0d_residue got=%h (frames=%0d) want=%h", n,
                        (res_q.size() > 0) ? res_q[0] : 32'h0, res_q.size(), CRC_RESIDUE);
      end
      total++;
      if (first_diff() != -1) begin
        bad++; $display("FAIL sweep_n%0d_stream got diff at %0d want identical", n, first_diff());
      end
    end
  endtask

  task automatic test_back_to_back();
    byte unsigned a[$], b[$];
    int wait_b;
    clear_rx();
    for (int i = 0; i < 15; i++) a.push_back(8'(8'hA0 + i));
    for (int i = 0; i < 11; i++) b.push_back(8'(8'h50 + 3 * i));
    send_frame(a);
    send_frame(b);
    wait_b = first_wait;
    idle(3);
    total++;
    if (wait_b != 1) begin bad++; $display("FAIL b2b_sop_stall got=%0d cycles want=1", wait_b); end
    total++;
    if (rx_sops != 2 || rx_eops != 2) begin
      bad++; $display("FAIL b2b_frames got sops=%0d eops=%0d want 2/2", rx_sops, rx_eops);
    end
    total++;
    if (first_diff() != -1) begin bad++; $display("FAIL b2b_stream got diff at %0d want identical", first_diff()); end
    total++;
    if (res_q.size() != 2 || res_q[0] !== CRC_RESIDUE || res_q[1] !== CRC_RESIDUE) begin
      bad++; $display("FAIL b2b_residue got frames=%0d want 2 frames of %h", res_q.size(), CRC_RESIDUE);
    end
  endtask

  task automatic test_midframe_sop();
    byte unsigned a[$], b[$];
    int w;
    clear_rx();
    for (int i = 0; i < 16; i++) a.push_back(8'(8'h10 + i));
    for (int i = 0; i < 10; i++) b.push_back(8'(8'hC3 ^ i));
    send_beat(pack_beat(a, 0), 1'b1, 1'b0, 3'd0, w);
    send_beat(pack_beat(a, 1), 1'b0, 1'b0, 3'd0, w);
    foreach (a[i]) exp_bytes.push_back(a[i]);   // truncated frame: data only
    send_frame(b);
    idle(3);
    total++;
    if (rx_sops != 2 || rx_eops != 1) begin
      bad++; $display("FAIL midsop_frames got sops=%0d eops=%0d want 2/1", rx_sops, rx_eops);
    end
    total++;
    if (first_diff() != -1) begin bad++; $display("FAIL midsop_stream got diff at %0d want identical", first_diff()); end
    total++;
    if (res_q.size() != 1 || res_q[0] !== CRC_RESIDUE) begin
      bad++; $display("FAIL midsop_residue got frames=%0d want 1 frame of %h", res_q.size(), CRC_RESIDUE);
    end
  endtask

  task automatic test_reset_midframe();
    byte unsigned f[$];
    int w;
    // Reset while in DATA.
    clear_rx();
    send_beat(64'h0102_0304_0506_0708, 1'b1, 1'b0, 3'd0, w);
    send_beat(64'h1112_1314_1516_1718, 1'b0, 1'b0, 3'd0, w);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    #2 reset = 1'b0;
    #1 check_outputs_zero("rst_data");
    @(negedge txclk);
    reset = 1'b1;
    clear_rx();
    for (int i = 0; i < 12; i++) f.push_back(8'(8'h77 + 5 * i));
    send_frame(f);
    idle(2);
    total++;
    if (first_diff() != -1 || res_q.size() != 1 || res_q[0] !== CRC_RESIDUE) begin
      bad++; $display("FAIL rst_data_next_frame got diff=%0d frames=%0d want identical, 1 good frame",
                      first_diff(), res_q.size());
    end

    // Reset while in EXTRA: the pending FCS bytes must never appear.
    clear_rx();
    f.delete();
    for (int i = 0; i < 14; i++) f.push_back(8'(8'h31 + i));
    send_frame(f);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_extra_entered got in_ready=%b want 0", in_ready); end
    #2 reset = 1'b0;
    #1 check_outputs_zero("rst_extra");
    @(negedge txclk);
    reset = 1'b1;
    clear_rx();
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_extra_no_fcs got out_valid=%b want 0", out_valid); end
    f.delete();
    for (int i = 0; i < 5; i++) f.push_back(8'(8'hE0 + i));
    send_frame(f);
    idle(2);
    total++;
    if (first_diff() != -1 || res_q.size() != 1 || res_q[0] !== CRC_RESIDUE) begin
      bad++; $display("FAIL rst_extra_next_frame got diff=%0d frames=%0d want identical, 1 good frame",
                      first_diff(), res_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_rx();
    test_reset();
    test_idle_drop();
    test_check_string();
    test_extra_beat();
    test_bytes_sweep();
    test_back_to_back();
    test_midframe_sop();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
